id_ex_pipe_reg: RTL
===================

// Module: id_ex_pipe_reg
// PURPOSE
//  ID/EX pipeline register of the 5-stage MIPS pipeline. Captures decoded control, the 2-bit ALU
//  operation class, funct field, operands, register addresses and PC+4 at the end of ID, and presents
//  them to EX, where the ALU control decoder consumes ex_alu_operation/ex_func. Supports stall (hold),
//  flush (bubble) and an optional built-in load-use hazard detector.
// PARAMETERS
//  DATA_W      32  operand / immediate / PC width
//  REG_ADDR_W  5   register-file address width
//  FUNC_W      6   R-type funct field width
//  CTRL_W      6   packed control bundle width (field map in mips_pipe_pkg)
// PORTS
//  clk               in  1          rising-edge clock; the only clock
//  rst_n             in  1          reset, asynchronous assert, active-low
//  stall             in  1          hold all EX-side contents this cycle
//  flush             in  1          replace next EX contents with a bubble (taken branch)
//  id_valid          in  1          ID holds a real instruction
//  id_ctrl           in  CTRL_W     {reg_dst,alu_src,mem_write,mem_read,mem_to_reg,reg_write}
//  id_alu_operation  in  2          00 lw/sw, 01 beq, 10 R-type, 11 slti
//  id_func           in  FUNC_W     instruction[5:0]
//  id_rd1, id_rd2    in  DATA_W     register-file read data
//  id_imm            in  DATA_W     sign-extended immediate
//  id_rs,id_rt,id_rd in  REG_ADDR_W source/destination register numbers
//  id_pc4            in  DATA_W     PC+4 of the ID instruction
//  ex_valid          out 1          EX holds a real instruction
//  ex_ctrl, ex_alu_operation, ex_func, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_pc4
//                    out            registered copies, same widths as the id_* inputs
//  hazard_stall      out 1          load-use stall request to PC and IF/ID (combinational)
// BEHAVIOUR
//  - Reset (rst_n=0, async): every ex_* output and ex_valid = 0; ex_alu_operation = 2'b00.
//  - Per rising edge, priority: flush > stall > hazard_stall > load.
//    flush: bubble. stall (flush=0): all registers hold. hazard_stall (flush=0, stall=0): bubble.
//    Otherwise load every ex_* from id_*, with ex_valid <= id_valid.
//  - Bubble = every ex_* field 0 and ex_valid 0. A bubble performs no reg/mem write; ALU class is 00.
//  - Latency is exactly 1 cycle ID->EX. No combinational path from id_* data to ex_*.
//  - If id_valid=0 on a load, ex_ctrl is forced to 0 regardless of id_ctrl.
//  - Release of rst_n mid-stream: first edge after release loads normally (no extra bubble).
// CONFIGURATION
//  - LOAD_USE_DETECT_EN defined: hazard_stall = ex_valid & ex_ctrl.mem_read & id_valid &
//    (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)). The block self-inserts a bubble and
//    upstream holds PC and IF/ID. Exactly one stall cycle per load-use pair.
//  - Not defined: hazard_stall tied 0; the external stall/flush sources handle all hazards.
// STRUCTURE
//  - mips_pipe_pkg: CTRL_* bit indices, ALUOP_MEM/ALUOP_BEQ/ALUOP_RTYPE/ALUOP_SLTI localparams,
//    and the CTRL_BUBBLE constant. Shared with the main control and ALU control decoders.
//  - One sub-module, load_use_detector (combinational), instantiated only under LOAD_USE_DETECT_EN.
// TESTING
//  1 Reset: rst_n=0 mid-cycle with loaded contents -> all ex_* = 0 immediately, without waiting for clk.
//  2 Load: add $3,$1,$2 (ctrl=6'b100001, op=10, func=6'h20, rd1=5, rd2=7) -> next cycle same values
//    on ex_*, with ex_valid=1.
//  3 Stall: hold stall=1 for 3 cycles while id_* changes -> ex_* remain unchanged. Release -> new id_* loads.
//  4 Flush+stall in the same cycle -> bubble (ex_ctrl=0, ex_valid=0). Flush wins.
//  5 Load-use (macro on): EX lw $5 (mem_read=1, rt=5), ID add uses rs=5 -> hazard_stall=1 and
//    one bubble is inserted. Repeat with rt=0 -> hazard_stall=0. With the macro off -> hazard_stall=0.
//  6 Load with id_valid=0 and id_ctrl=6'b111111 -> ex_ctrl=0, ex_valid=0.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: control-bundle bit map, ALU operation classes, bubble constant.
// Used by the main control decoder, the ALU control decoder and the ID/EX register.
package mips_pipe_pkg;

  localparam int unsigned CTRL_BUS_W = 6;
  localparam int unsigned ALUOP_W    = 2;

  // Control bundle is {reg_dst, alu_src, mem_write, mem_read, mem_to_reg, reg_write}
  localparam int unsigned CTRL_REG_WRITE  = 0;
  localparam int unsigned CTRL_MEM_TO_REG = 1;
  localparam int unsigned CTRL_MEM_READ   = 2;
  localparam int unsigned CTRL_MEM_WRITE  = 3;
  localparam int unsigned CTRL_ALU_SRC    = 4;
  localparam int unsigned CTRL_REG_DST    = 5;

  localparam logic [ALUOP_W-1:0] ALUOP_MEM   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_SLTI  = 2'b11;

  // A bubble asserts no write enables and no memory access
  localparam logic [CTRL_BUS_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detector.sv
// Load-use hazard detector: flags an ID instruction reading the register an EX-stage load writes.
// Only built when LOAD_USE_DETECT_EN is defined.
`ifdef LOAD_USE_DETECT_EN
module load_use_detector #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  output logic                  hazard_stall_c
);

  logic rt_nonzero;
  logic rt_match;

  // $zero is never a real dependency
  always_comb begin
    rt_nonzero     = (ex_rt != '0);
    rt_match       = (ex_rt == id_rs) || (ex_rt == id_rt);
    hazard_stall_c = ex_valid && ex_mem_read && id_valid && rt_nonzero && rt_match;
  end

endmodule
`endif

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall hold, flush bubble and optional load-use bubble insertion.
// Define LOAD_USE_DETECT_EN to build the internal load-use detector; otherwise hazard_stall is 0.
module id_ex_pipe_reg
  import mips_pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned FUNC_W     = 6,
  parameter int unsigned CTRL_W     = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [CTRL_W-1:0]     id_ctrl,
  input  logic [1:0]            id_alu_operation,
  input  logic [FUNC_W-1:0]     id_func,
  input  logic [DATA_W-1:0]     id_rd1,
  input  logic [DATA_W-1:0]     id_rd2,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [DATA_W-1:0]     id_pc4,
  output logic                  ex_valid,
  output logic [CTRL_W-1:0]     ex_ctrl,
  output logic [1:0]            ex_alu_operation,
  output logic [FUNC_W-1:0]     ex_func,
  output logic [DATA_W-1:0]     ex_rd1,
  output logic [DATA_W-1:0]     ex_rd2,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [DATA_W-1:0]     ex_pc4,
  output logic                  hazard_stall
);

  logic                  valid_q,  valid_d;
  logic [CTRL_W-1:0]     ctrl_q,   ctrl_d;
  logic [1:0]            aluop_q,  aluop_d;
  logic [FUNC_W-1:0]     func_q,   func_d;
  logic [DATA_W-1:0]     rd1_q,    rd1_d;
  logic [DATA_W-1:0]     rd2_q,    rd2_d;
  logic [DATA_W-1:0]     imm_q,    imm_d;
  logic [REG_ADDR_W-1:0] rs_q,     rs_d;
  logic [REG_ADDR_W-1:0] rt_q,     rt_d;
  logic [REG_ADDR_W-1:0] rd_q,     rd_d;
  logic [DATA_W-1:0]     pc4_q,    pc4_d;

  logic                  bubble_c;
  logic                  load_c;

`ifdef LOAD_USE_DETECT_EN
  load_use_detector #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detector (
    .ex_valid       (valid_q),
    .ex_mem_read    (ctrl_q[CTRL_MEM_READ]),
    .ex_rt          (rt_q),
    .id_valid       (id_valid),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .hazard_stall_c (hazard_stall)
  );
`else
  assign hazard_stall = 1'b0;
`endif

  // Priority: flush > stall > hazard bubble > load
  always_comb begin
    bubble_c = flush || (!stall && hazard_stall);
    load_c   = !flush && !stall && !hazard_stall;
  end

  // Next-state selection: hold by default, then bubble or load
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    aluop_d = aluop_q;
    func_d  = func_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    pc4_d   = pc4_q;

    if (bubble_c) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_W'(CTRL_BUBBLE);
      aluop_d = ALUOP_MEM;
      func_d  = '0;
      rd1_d   = '0;
      rd2_d   = '0;
      imm_d   = '0;
      rs_d    = '0;
      rt_d    = '0;
      rd_d    = '0;
      pc4_d   = '0;
    end else if (load_c) begin
      valid_d = id_valid;
      // An invalid slot must never carry write enables into EX
      ctrl_d  = id_valid ? id_ctrl : CTRL_W'(CTRL_BUBBLE);
      aluop_d = id_alu_operation;
      func_d  = id_func;
      rd1_d   = id_rd1;
      rd2_d   = id_rd2;
      imm_d   = id_imm;
      rs_d    = id_rs;
      rt_d    = id_rt;
      rd_d    = id_rd;
      pc4_d   = id_pc4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      aluop_q <= ALUOP_MEM;
      func_q  <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      aluop_q <= aluop_d;
      func_q  <= func_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      pc4_q   <= pc4_d;
    end
  end

  assign ex_valid         = valid_q;
  assign ex_ctrl          = ctrl_q;
  assign ex_alu_operation = aluop_q;
  assign ex_func          = func_q;
  assign ex_rd1           = rd1_q;
  assign ex_rd2           = rd2_q;
  assign ex_imm           = imm_q;
  assign ex_rs            = rs_q;
  assign ex_rt            = rt_q;
  assign ex_rd            = rd_q;
  assign ex_pc4           = pc4_q;

endmodule
